mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer that shares one WIDTH-bit 4:1 mux datapath among
//   four requesters. Picks a winner, drives the mux selects, and forwards the winner's
//   data downstream with a valid/ready handshake. Each tenure is capped at MAX_BURST beats.
//   Sits between four producer blocks and a single shared downstream consumer.
// PARAMETERS
//   WIDTH      8   data width per requester and of out_data
//   MAX_BURST  4   max beats per grant tenure (>=1); counter width = $clog2(MAX_BURST)+1
// PORTS
//   clk        in   1        single system clock, rising edge
//   reset      in   1        synchronous, active-high reset
//   req        in   4        req[i]=1: requester i has a beat on in_data[i]
//   in_data    in   4*WIDTH  packed; requester i at [i*WIDTH +: WIDTH]
//   gnt        out  4        one-hot tenure grant, registered
//   ack        out  4        one-hot beat accept: ack[i] = gnt[i] & req[i] & out_ready
//   sel        out  2        registered mux select (sel[1]=s1, sel[0]=s0)
//   out_valid  out  1        out_valid = (state==GRANT) & req[sel]
//   out_data   out  WIDTH    in_data word selected by sel (combinational through mux)
//   out_ready  in   1        downstream accepts beat when out_valid & out_ready
//   busy       out  1        1 while state==GRANT
// BEHAVIOUR
//   - Clock/reset: one clock; reset is synchronous and active-high.
//   - Reset values: state=IDLE, ptr=0, sel=0, gnt=0, cnt=0.
//     Combinational outputs then give ack=0, out_valid=0, busy=0.
//     out_data follows in_data[0] while sel=0.
//   - Reset mid-tenure: at the reset edge the grant is dropped and no beat transfers
//     (out_valid is masked during reset). ptr returns to 0.
//   - IDLE: gnt=0, out_valid=0.
//     If |req, the winner is the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
//     Next edge: sel<=winner, gnt<=1<<winner, cnt<=0, state<=GRANT.
//     Latency: req seen in cycle N -> gnt/sel valid in cycle N+1.
//     First beat can transfer in N+1.
//   - GRANT: a transfer happens when out_valid & out_ready; each transfer does cnt<=cnt+1.
//     Tenure ends (next state IDLE, gnt<=0, ptr<=sel+1 mod 4) when either:
//       (a) req[sel]==0 (requester releases; no transfer this cycle), or
//       (b) a transfer occurs with cnt==MAX_BURST-1.
//     Otherwise stay in GRANT; sel and gnt are held stable.
//   - Stall: out_ready=0 while out_valid=1 -> hold. No beat counted; out_data stays stable
//     as long as the requester holds in_data.
//   - Inter-tenure bubble: exactly one IDLE cycle between tenures (fixed, by design).
//   - Fairness: ptr advances past the last winner, so a continuously requesting set
//     is served 0->1->2->3->0.
//     A sole requester is re-granted after the one-cycle bubble.
//   - Simultaneous events:
//     * req[sel] drops while other requesters are pending -> IDLE, then winner by ptr.
//     * Changes to non-selected req bits during GRANT are ignored until IDLE.
//   - ptr wraps 3->0; cnt never exceeds MAX_BURST-1.
//   - MAX_BURST=1 gives single-beat tenures.
// STRUCTURE
//   - Package mux4_arb_pkg holds: state encoding (IDLE=1'b0, GRANT=1'b1),
//     N_REQ=4, SEL_W=2.
//   - Sub-module rr_pick4: combinational rotate-priority picker (req[3:0], ptr[1:0])
//     -> winner[1:0], any.
//   - Datapath: WIDTH instances of the team's 1-bit 4:1 mux cell MUX4X1
//     (i0..i3, s0, s1, out), generated per bit.
//   - FSM, cnt, ptr, sel and gnt are registers in this module.
// TESTING
//   1. Reset held 2 cycles with req=4'b1111
//      -> gnt=0, out_valid=0, busy=0, sel=0 throughout reset.
//   2. req=4'b0100, in_data[2]=8'hA5, out_ready=1 from cycle 0
//      -> cycle 1: sel=2, gnt=4'b0100, out_data=8'hA5, out_valid=1.
//      -> Exactly 4 beats are acked, then gnt=0 for one cycle.
//   3. req=4'b1111 held, out_ready=1
//      -> tenures granted in order 0,1,2,3,0, each 4 beats with one bubble between.
//   4. Grant to requester 1, out_ready=0 for 3 cycles, then 1
//      -> sel/gnt held, cnt unchanged while stalled.
//      -> ack[1] pulses only once out_ready=1.
//   5. Requester 3 drops req after 2 beats while req[0]=1
//      -> IDLE for 1 cycle, then gnt=4'b0001 (ptr wraps 3->0).
//   6. reset asserted mid-tenure (cnt=2)
//      -> next cycle gnt=0, out_valid=0, ptr=0.
//      -> After release with req=4'b1010, sel=1.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared constants for the four-way round-robin mux arbiter.
// State encoding is kept as plain constants so older netlists stay compatible.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/MUX4X1.sv
// One-bit 4:1 mux cell; s1 picks the upper/lower pair, s0 picks within the pair.
module MUX4X1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic out
);

  assign out = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: scans ptr, ptr+1, ... (mod 4) and reports the first
// asserted request as the winner.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    any    = |req;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 4:1 mux among four requesters,
// with tenures capped at MAX_BURST beats and a fixed one-cycle bubble between tenures.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] winner;
  logic             anyReq;
  logic             xfer;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (anyReq)
  );

  genvar b;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_mux
      MUX4X1 u_mux (
        .i0  (in_data[0*WIDTH + b]),
        .i1  (in_data[1*WIDTH + b]),
        .i2  (in_data[2*WIDTH + b]),
        .i3  (in_data[3*WIDTH + b]),
        .s0  (sel_q[0]),
        .s1  (sel_q[1]),
        .out (out_data[b])
      );
    end
  endgenerate

  // Reset masks the handshake so no beat can slip through on the reset edge.
  assign out_valid = (state_q == GRANT) & req[sel_q] & ~reset;
  assign xfer      = out_valid & out_ready;
  assign ack       = gnt_q & req & {N_REQ{out_ready & ~reset}};
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (anyReq) begin
        state_d = GRANT;
        sel_d   = winner;
        gnt_d   = N_REQ'(1) << winner;
        cnt_d   = '0;
      end
    end else begin
      // A release or the final beat of a burst both close the tenure.
      if (!req[sel_q] || (xfer && cnt_q == LAST_BEAT)) begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = sel_q + SEL_W'(1);
        cnt_d   = '0;
      end else if (xfer) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a rule-level model predicts each cycle's
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_mux4_rr_arbiter;

  localparam int W     = 8;
  localparam int BURST = 4;

  logic           clk;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] in_data;
  logic [3:0]     gnt;
  logic [3:0]     ack;
  logic [1:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           busy;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   gnt;
    logic [3:0]   ack;
    logic [1:0]   sel;
    logic         valid;
    logic [W-1:0] data;
    logic         busy;
  } expect_t;

  expect_t expQ[$];
  int      orderQ[$];
  int      compared   = 0;
  int      mismatched = 0;
  bit      logOrder   = 0;
  logic [3:0] prevGnt = 4'b0;

  // Model state: current owner (-1 when idle), beats taken, rotation pointer, last select.
  int mOwner   = -1;
  int mBeats   = 0;
  int mPtr     = 0;
  int mLastSel = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] randData();
    logic [4*W-1:0] d;
    for (int i = 0; i < 4; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  function automatic int pickWinner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic rdy,
                               input logic [4*W-1:0] d);
    expect_t e;
    int w;
    @(posedge clk);
    #1;
    reset     = rst;
    req       = r;
    out_ready = rdy;
    in_data   = d;

    e.busy  = (mOwner >= 0);
    e.gnt   = (mOwner >= 0) ? (4'b1 << mOwner) : 4'b0;
    e.sel   = 2'(mLastSel);
    e.valid = !rst && (mOwner >= 0) && r[mOwner];
    e.ack   = (e.valid && rdy) ? (4'b1 << mOwner) : 4'b0;
    e.data  = d[mLastSel*W +: W];
    expQ.push_back(e);

    if (rst) begin
      mOwner = -1; mBeats = 0; mPtr = 0; mLastSel = 0;
    end else if (mOwner < 0) begin
      w = pickWinner(r, mPtr);
      if (w >= 0) begin
        mOwner = w; mLastSel = w; mBeats = 0;
      end
    end else if (!r[mOwner]) begin
      mPtr = (mOwner + 1) % 4;
      mOwner = -1;
    end else if (rdy) begin
      mBeats++;
      if (mBeats == BURST) begin
        mPtr = (mOwner + 1) % 4;
        mOwner = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("gnt",       32'(gnt),       32'(e.gnt));
      checkOutput("ack",       32'(ack),       32'(e.ack));
      checkOutput("sel",       32'(sel),       32'(e.sel));
      checkOutput("out_valid", 32'(out_valid), 32'(e.valid));
      checkOutput("out_data",  32'(out_data),  32'(e.data));
      checkOutput("busy",      32'(busy),      32'(e.busy));
    end
    if (logOrder && prevGnt == 4'b0 && gnt != 4'b0) begin
      for (int i = 0; i < 4; i++) if (gnt[i]) orderQ.push_back(i);
    end
    prevGnt = gnt;
  end

  initial begin
    int expOrder[5];
    logic [3:0] r;
    logic [4*W-1:0] d;
    expOrder = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = 4'b1111; out_ready = 1'b0; in_data = '0;

    // Reset held with every requester active.
    repeat (2) applyStimulus(1'b1, 4'b1111, 1'b1, randData());

    // Sole requester 2 with a fixed data word: four beats, then the bubble.
    d = randData();
    d[2*W +: W] = 8'hA5;
    repeat (8) applyStimulus(1'b0, 4'b0100, 1'b1, d);

    // All four requesting from ptr=0: tenures in order 0,1,2,3,0.
    applyStimulus(1'b1, 4'b0000, 1'b1, randData());
    logOrder = 1;
    repeat (26) applyStimulus(1'b0, 4'b1111, 1'b1, randData());
    @(negedge clk);
    logOrder = 0;
    checkOutput("order_len", 32'(orderQ.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < orderQ.size(); i++)
      checkOutput("grant_order", 32'(orderQ[i]), 32'(expOrder[i]));

    // Requester 1 stalled for three cycles, then drained.
    applyStimulus(1'b1, 4'b0000, 1'b1, randData());
    applyStimulus(1'b0, 4'b0010, 1'b0, randData());
    repeat (3) applyStimulus(1'b0, 4'b0010, 1'b0, randData());
    repeat (5) applyStimulus(1'b0, 4'b0010, 1'b1, randData());
    applyStimulus(1'b0, 4'b0000, 1'b1, randData());

    // Requester 3 releases after two beats while requester 0 waits.
    applyStimulus(1'b1, 4'b0000, 1'b1, randData());
    applyStimulus(1'b0, 4'b1000, 1'b1, randData());
    repeat (2) applyStimulus(1'b0, 4'b1001, 1'b1, randData());
    repeat (4) applyStimulus(1'b0, 4'b0001, 1'b1, randData());

    // Reset in the middle of a tenure, then requesters 1 and 3.
    applyStimulus(1'b1, 4'b0000, 1'b1, randData());
    applyStimulus(1'b0, 4'b0001, 1'b1, randData());
    repeat (2) applyStimulus(1'b0, 4'b0001, 1'b1, randData());
    applyStimulus(1'b1, 4'b0001, 1'b1, randData());
    repeat (4) applyStimulus(1'b0, 4'b1010, 1'b1, randData());

    // Randomized traffic with occasional resets.
    r = 4'b0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) r = r ^ (4'b1 << $urandom_range(0, 3));
      applyStimulus($urandom_range(0, 199) == 0, r, $urandom_range(0, 3) != 0, randData());
    end

    @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
